// File: rtl/wash_pkg.sv
// Shared codes, per-mode timing tables and BCD helper for the wash program sequencer.
// Pure declarations, so there is no latency and no backpressure.
package wash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_WASH  = 2'b01;
  localparam logic [1:0] PH_RINSE = 2'b10;
  localparam logic [1:0] PH_SPIN  = 2'b11;

  localparam logic [3:0] ACT_IDLE     = 4'd0;
  localparam logic [3:0] ACT_ROTATE   = 4'd1;
  localparam logic [3:0] ACT_STEW     = 4'd2;
  localparam logic [3:0] ACT_ADDWATER = 4'd3;
  localparam logic [3:0] ACT_DRAIN    = 4'd4;
  localparam logic [3:0] ACT_FSPIN    = 4'd5;
  localparam logic [3:0] ACT_RSPIN    = 4'd6;
  localparam logic [3:0] ACT_OFF      = 4'd10;

  localparam logic [3:0] LVL_FULL = 4'd8;

  // Seconds spent in each phase; spin-only runs its single phase for 15 s.
  function automatic logic [4:0] phase_len(input logic [1:0] m);
    case (m)
      2'b00:   return 5'd15;
      2'b01:   return 5'd10;
      2'b10:   return 5'd15;
      default: return 5'd20;
    endcase
  endfunction

  // Whole-program duration as two BCD digits {tens, ones}.
  function automatic logic [7:0] total_bcd(input logic [1:0] m);
    case (m)
      2'b00:   return 8'h15;
      2'b01:   return 8'h30;
      2'b10:   return 8'h45;
      default: return 8'h60;
    endcase
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)
      return v;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [3:0] action_of(input logic [1:0] ph, input logic [4:0] step);
    case (ph)
      PH_WASH:  return step[0] ? ACT_STEW : ACT_ROTATE;
      PH_RINSE: begin
        case (step % 5'd3)
          5'd0:    return ACT_ADDWATER;
          5'd1:    return ACT_ROTATE;
          default: return ACT_DRAIN;
        endcase
      end
      PH_SPIN: begin
        case (step[1:0])
          2'd0:    return ACT_FSPIN;
          2'd2:    return ACT_RSPIN;
          default: return ACT_DRAIN;
        endcase
      end
      default:  return ACT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wash_program_sequencer_if.sv
// Button-side controls and display/lamp-side status of the wash program sequencer.
// Plain wires: no latency; pulses are single-cycle and never backpressured.
interface wash_program_sequencer_if;
  logic       en;
  logic       start_p;
  logic       abort_p;
  logic [1:0] mode;
  logic [1:0] phase;
  logic [3:0] action;
  logic [3:0] rem_tens;
  logic [3:0] rem_ones;
  logic [3:0] water_lvl;
  logic       busy;
  logic       paused;
  logic       done;

  modport master (
    output en, start_p, abort_p, mode,
    input  phase, action, rem_tens, rem_ones, water_lvl, busy, paused, done
  );

  modport slave (
    input  en, start_p, abort_p, mode,
    output phase, action, rem_tens, rem_ones, water_lvl, busy, paused, done
  );
endinterface

// File: rtl/wash_tick_gen.sv
// Prescaler giving a one-second tick and eighth-second strobes while counting is enabled.
// Strobes decode the registered count (0 cycles); holding run low freezes the count.
module wash_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick,
  output logic eighth
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SUB_MAX = CW'(TICK_DIV / 8 - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] sub;

  // sub wraps eight times per cnt period because TICK_DIV is a multiple of 8.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sub <= '0;
    end else if (clr) begin
      cnt <= '0;
      sub <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      sub <= (sub == SUB_MAX) ? '0 : sub + CW'(1);
    end
  end

  assign tick   = run && (cnt == CNT_MAX);
  assign eighth = run && (sub == SUB_MAX);

endmodule

// File: rtl/wash_program_sequencer.sv
// Washer program controller: WASH -> RINSE -> SPIN on a 1 s time base with pause/abort.
// Outputs update on the edge closing a tick cycle; en low freezes everything, no backpressure.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  wash_program_sequencer_if.slave  bus
);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] phase_q, phase_d;
  logic [4:0] sec_q, sec_d;
  logic [4:0] step_q, step_d;
  logic [7:0] rem_q, rem_d;
  logic [3:0] lvl_q, lvl_d;
  logic [3:0] act_q, act_d;
  logic       busy_q, busy_d;
  logic       paused_q, paused_d;
  logic       done_q, done_d;

  logic       run;
  logic       clr;
  logic       tick;
  logic       eighth;
  logic       go_idle;
  logic [4:0] sec_inc;

  assign run = bus.en && (state_q == ST_RUN);
  assign clr = bus.en && ((state_q == ST_IDLE) || (state_d == ST_IDLE));

  wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .clr    (clr),
    .tick   (tick),
    .eighth (eighth)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    sec_d   = sec_q;
    step_d  = step_q;
    rem_d   = rem_q;
    lvl_d   = lvl_q;
    act_d   = act_q;
    go_idle = 1'b0;
    sec_inc = sec_q + 5'd1;

    if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_p) begin
            state_d = ST_RUN;
            mode_d  = bus.mode;
            rem_d   = total_bcd(bus.mode);
            sec_d   = '0;
            step_d  = '0;
            phase_d = (bus.mode == 2'b00) ? PH_SPIN : PH_WASH;
            lvl_d   = (bus.mode == 2'b00) ? 4'd0 : LVL_FULL;
            act_d   = action_of(phase_d, 5'd0);
          end
        end
        ST_RUN: begin
          if (eighth) begin
            if (act_q == ACT_ADDWATER && lvl_q != LVL_FULL)
              lvl_d = lvl_q + 4'd1;
            else if (act_q == ACT_DRAIN && lvl_q != 4'd0)
              lvl_d = lvl_q - 4'd1;
          end
          if (tick) begin
            rem_d  = bcd_dec(rem_q);
            sec_d  = sec_inc;
            step_d = step_q + 5'd1;
            if (sec_inc == phase_len(mode_q)) begin
              sec_d  = '0;
              step_d = '0;
              if (phase_q == PH_SPIN)
                state_d = ST_DONE;
              else
                phase_d = phase_q + 2'd1;
            end
            if (state_d == ST_DONE) begin
              act_d = ACT_OFF;
              lvl_d = 4'd0;
              rem_d = 8'h00;
            end else begin
              act_d = action_of(phase_d, step_d);
            end
          end
          // A start pulse that lands on a tick pauses only after the tick is taken.
          if (bus.start_p && state_d == ST_RUN)
            state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (bus.start_p)
            state_d = ST_RUN;
        end
        default: begin
          if (bus.start_p)
            go_idle = 1'b1;
        end
      endcase

      if (bus.abort_p && state_q != ST_IDLE)
        go_idle = 1'b1;

      if (go_idle) begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
        sec_d   = '0;
        step_d  = '0;
        rem_d   = 8'h00;
        lvl_d   = 4'd0;
        act_d   = ACT_IDLE;
      end
    end

    busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    paused_d = (state_d == ST_PAUSE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'b00;
      phase_q  <= PH_IDLE;
      sec_q    <= '0;
      step_q   <= '0;
      rem_q    <= 8'h00;
      lvl_q    <= 4'd0;
      act_q    <= ACT_IDLE;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      sec_q    <= sec_d;
      step_q   <= step_d;
      rem_q    <= rem_d;
      lvl_q    <= lvl_d;
      act_q    <= act_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.action    = act_q;
  assign bus.rem_tens  = rem_q[7:4];
  assign bus.rem_ones  = rem_q[3:0];
  assign bus.water_lvl = lvl_q;
  assign bus.busy      = busy_q;
  assign bus.paused    = paused_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer with an 8-cycle second.
module tb_wash_program_sequencer;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wash_program_sequencer_if bus();

  wash_program_sequencer #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start_p = 1'b1;
    cyc(1);
    bus.start_p = 1'b0;
  endtask

  function automatic logic [7:0] rem();
    return {bus.rem_tens, bus.rem_ones};
  endfunction

  initial begin
    bus.en      = 1'b1;
    bus.start_p = 1'b0;
    bus.abort_p = 1'b0;
    bus.mode    = 2'b01;
    #12;
    chk("rst_phase", 8'(bus.phase), 8'd0);
    chk("rst_action", 8'(bus.action), 8'd0);
    chk("rst_rem", rem(), 8'h00);
    chk("rst_lvl", 8'(bus.water_lvl), 8'd0);
    chk("rst_flags", 8'({bus.busy, bus.paused, bus.done}), 8'd0);
    rst = 1'b1;
    cyc(2);

    // Mode 01 full program
    pulse_start();
    chk("m1_phase0", 8'(bus.phase), 8'd1);
    chk("m1_act0", 8'(bus.action), 8'd1);
    chk("m1_rem0", rem(), 8'h30);
    chk("m1_lvl0", 8'(bus.water_lvl), 8'd8);
    chk("m1_busy0", 8'(bus.busy), 8'd1);
    cyc(7);
    chk("m1_rem_pre", rem(), 8'h30);
    cyc(1);
    chk("m1_act1", 8'(bus.action), 8'd2);
    chk("m1_rem1", rem(), 8'h29);
    cyc(72);
    chk("m1_rinse_ph", 8'(bus.phase), 8'd2);
    chk("m1_rinse_act", 8'(bus.action), 8'd3);
    chk("m1_rinse_rem", rem(), 8'h20);
    cyc(16);
    chk("m1_drain_act", 8'(bus.action), 8'd4);
    chk("m1_drain_lvl0", 8'(bus.water_lvl), 8'd8);
    cyc(4);
    chk("m1_drain_lvl4", 8'(bus.water_lvl), 8'd4);
    cyc(4);
    chk("m1_drain_lvl8", 8'(bus.water_lvl), 8'd0);
    chk("m1_fill_act", 8'(bus.action), 8'd3);
    cyc(8);
    chk("m1_fill_lvl", 8'(bus.water_lvl), 8'd8);
    chk("m1_fill_rem", rem(), 8'h16);
    cyc(127);
    chk("m1_pre_done", 8'(bus.done), 8'd0);
    chk("m1_pre_rem", rem(), 8'h01);
    cyc(1);
    chk("m1_done", 8'(bus.done), 8'd1);
    chk("m1_done_rem", rem(), 8'h00);
    chk("m1_done_act", 8'(bus.action), 8'd10);
    chk("m1_done_ph", 8'(bus.phase), 8'd3);
    chk("m1_done_lvl", 8'(bus.water_lvl), 8'd0);
    chk("m1_done_busy", 8'(bus.busy), 8'd0);
    pulse_start();
    chk("m1_clr_ph", 8'(bus.phase), 8'd0);
    chk("m1_clr_act", 8'(bus.action), 8'd0);
    chk("m1_clr_done", 8'(bus.done), 8'd0);

    // Spin-only
    bus.mode = 2'b00;
    pulse_start();
    chk("m0_ph", 8'(bus.phase), 8'd3);
    chk("m0_act0", 8'(bus.action), 8'd5);
    chk("m0_rem0", rem(), 8'h15);
    chk("m0_lvl0", 8'(bus.water_lvl), 8'd0);
    cyc(8);
    chk("m0_act1", 8'(bus.action), 8'd4);
    chk("m0_rem1", rem(), 8'h14);
    cyc(8);
    chk("m0_act2", 8'(bus.action), 8'd6);
    cyc(8);
    chk("m0_act3", 8'(bus.action), 8'd4);
    cyc(8);
    chk("m0_act4", 8'(bus.action), 8'd5);
    chk("m0_rem4", rem(), 8'h11);
    cyc(87);
    chk("m0_pre_done", 8'(bus.done), 8'd0);
    cyc(1);
    chk("m0_done", 8'(bus.done), 8'd1);
    chk("m0_done_rem", rem(), 8'h00);
    pulse_start();

    // Pause / resume
    bus.mode = 2'b11;
    pulse_start();
    chk("p_rem0", rem(), 8'h60);
    cyc(24);
    chk("p_rem57", rem(), 8'h57);
    cyc(3);
    pulse_start();
    chk("p_paused", 8'(bus.paused), 8'd1);
    cyc(40);
    chk("p_hold_rem", rem(), 8'h57);
    chk("p_hold_act", 8'(bus.action), 8'd2);
    chk("p_hold_flags", 8'({bus.busy, bus.paused}), 8'd3);
    pulse_start();
    chk("p_resumed", 8'(bus.paused), 8'd0);
    cyc(3);
    chk("p_res_rem57", rem(), 8'h57);
    cyc(1);
    chk("p_res_rem56", rem(), 8'h56);
    chk("p_res_act", 8'(bus.action), 8'd1);

    // Abort together with start
    bus.abort_p = 1'b1;
    bus.start_p = 1'b1;
    cyc(1);
    bus.abort_p = 1'b0;
    bus.start_p = 1'b0;
    chk("ab_ph", 8'(bus.phase), 8'd0);
    chk("ab_act", 8'(bus.action), 8'd0);
    chk("ab_rem", rem(), 8'h00);
    chk("ab_flags", 8'({bus.busy, bus.paused, bus.done}), 8'd0);

    // Mode changes mid-run are ignored
    bus.mode = 2'b10;
    pulse_start();
    chk("mt_rem0", rem(), 8'h45);
    bus.mode = 2'b01;
    cyc(80);
    chk("mt_ph10", 8'(bus.phase), 8'd1);
    chk("mt_rem10", rem(), 8'h35);
    cyc(40);
    chk("mt_ph15", 8'(bus.phase), 8'd2);
    chk("mt_rem15", rem(), 8'h30);

    // Enable low freezes everything and ignores pulses
    cyc(3);
    bus.en = 1'b0;
    cyc(5);
    pulse_start();
    cyc(14);
    chk("en_rem", rem(), 8'h30);
    chk("en_ph", 8'(bus.phase), 8'd2);
    chk("en_act", 8'(bus.action), 8'd3);
    chk("en_lvl", 8'(bus.water_lvl), 8'd8);
    chk("en_flags", 8'({bus.busy, bus.paused}), 8'd2);
    bus.en = 1'b1;
    cyc(4);
    chk("en_rem_pre", rem(), 8'h30);
    cyc(1);
    chk("en_rem_post", rem(), 8'h29);

    // Asynchronous reset mid-rinse
    cyc(10);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_ph", 8'(bus.phase), 8'd0);
    chk("ar_act", 8'(bus.action), 8'd0);
    chk("ar_rem", rem(), 8'h00);
    chk("ar_lvl", 8'(bus.water_lvl), 8'd0);
    chk("ar_busy", 8'(bus.busy), 8'd0);
    #2;
    rst = 1'b1;
    cyc(2);
    chk("ar_idle_ph", 8'(bus.phase), 8'd0);
    pulse_start();
    chk("ar_restart_rem", rem(), 8'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
